// File: rtl/req_gnt_delay_checker_if.sv
// Request/grant monitor bus: stimulus side (master) drives req/gnt/clr,
// checker side (slave) returns per-channel verdicts and aggregate counters.
interface req_gnt_delay_checker_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   gnt;
  logic             clr;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   pass;
  logic [NCH-1:0]   fail;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  // req/gnt are level inputs sampled on every posedge; there is no back-pressure,
  // pass/fail are single-cycle pulses and pending mirrors each channel's WAIT state.
  modport master (
    output req, gnt, clr,
    input  pending, pass, fail, pass_cnt, fail_cnt
  );

  modport slave (
    input  req, gnt, clr,
    output pending, pass, fail, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/req_gnt_delay_checker.sv
// Per-channel "req implies gnt within MIN_DLY..MAX_DLY clocks" monitor with
// registered pass/fail pulses and saturating aggregate counters.
module req_gnt_delay_checker #(
  parameter int NCH       = 4,
  parameter int MIN_DLY   = 3,
  parameter int MAX_DLY   = 3,
  parameter int UNBOUNDED = 0,
  parameter int CNT_W     = 8
) (
  input logic                    clk,
  input logic                    rst,
  req_gnt_delay_checker_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0]       MIN_K   = 8'(MIN_DLY);
  localparam logic [7:0]       MAX_K   = 8'(MAX_DLY);
  localparam logic [CNT_W+5:0] SAT_SUM = {6'd0, {CNT_W{1'b1}}};

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [7:0]       k_q     [NCH];
  logic [7:0]       k_d     [NCH];
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   pass_q, pass_d;
  logic [NCH-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W+5:0] pass_sum, fail_sum;

  always_comb begin
    pass_d    = '0;
    fail_d    = '0;
    pending_d = '0;
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      k_d[c]     = k_q[c];
      if (bus.clr) begin
        state_d[c] = IDLE;
        k_d[c]     = 8'd0;
      end else begin
        case (state_q[c])
          IDLE: begin
            if (bus.req[c]) begin
              if (MIN_DLY == 0 && bus.gnt[c]) begin
                pass_d[c] = 1'b1;
              end else begin
                state_d[c] = WAIT;
                k_d[c]     = 8'd1;
              end
            end
          end
          WAIT: begin
            // Unbounded mode never times out; k just parks at 255.
            if (k_q[c] >= MIN_K && (UNBOUNDED != 0 || k_q[c] <= MAX_K) && bus.gnt[c]) begin
              pass_d[c]  = 1'b1;
              state_d[c] = IDLE;
              k_d[c]     = 8'd0;
            end else if (UNBOUNDED == 0 && k_q[c] == MAX_K && k_q[c] >= MIN_K) begin
              fail_d[c]  = 1'b1;
              state_d[c] = IDLE;
              k_d[c]     = 8'd0;
            end else if (k_q[c] != 8'hFF) begin
              k_d[c] = k_q[c] + 8'd1;
            end
          end
          default: begin
            state_d[c] = IDLE;
            k_d[c]     = 8'd0;
          end
        endcase
      end
      pending_d[c] = (state_d[c] == WAIT);
    end

    pass_sum = {6'd0, pass_cnt_q};
    fail_sum = {6'd0, fail_cnt_q};
    for (int c = 0; c < NCH; c++) begin
      pass_sum = pass_sum + {{(CNT_W+5){1'b0}}, pass_d[c]};
      fail_sum = fail_sum + {{(CNT_W+5){1'b0}}, fail_d[c]};
    end

    if (bus.clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      pass_cnt_d = (pass_sum > SAT_SUM) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
      fail_cnt_d = (fail_sum > SAT_SUM) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        k_q[c]     <= 8'd0;
      end
      pending_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        k_q[c]     <= k_d[c];
      end
      pending_q  <= pending_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.pending  = pending_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;

endmodule

// File: doc/req_gnt_delay_checker.md
# req_gnt_delay_checker

Synthesizable multi-channel monitor that checks the rule "req implies gnt after a delay of MIN_DLY..MAX_DLY clocks" on every channel. It can also run in an unbounded mode. It gives the same verdicts as the bench-level constant, range and unbounded delay assertions. It can therefore be placed in RTL, FPGA builds or emulation, where SVA is unavailable. Per-channel pass/fail pulses and saturating aggregate counters feed debug status registers.

## Interface
- NCH, 4: number of independent req/gnt channels (1..32).
- MIN_DLY, 3: earliest sampled cycle, relative to the trigger edge, at which gnt is accepted (0..255).
- MAX_DLY, 3: latest sampled cycle at which gnt is accepted. MAX_DLY >= MIN_DLY. MIN_DLY == MAX_DLY gives a constant delay. Ignored when UNBOUNDED = 1.
- UNBOUNDED, 0: 1 = no upper bound on the delay (##[MIN_DLY:$] behaviour).
- CNT_W, 8: width of the pass/fail counters.
- clk  in  1  single clock; all sampling on the posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NCH  per-channel request.
- gnt  in  NCH  per-channel grant.
- clr  in  1  synchronous clear of the counters and of all pending attempts.
- pending  out  NCH  channel has an armed attempt awaiting its verdict.
- pass  out  NCH  one-cycle pulse: the attempt succeeded.
- fail  out  NCH  one-cycle pulse: the attempt failed.
- pass_cnt  out  CNT_W  total passes, saturating.
- fail_cnt  out  CNT_W  total fails, saturating.

## Operation
- Each channel has its own FSM with two states, IDLE and WAIT, and a delay counter k (8 bits).
- IDLE, req = 1 sampled (trigger edge):
  - MIN_DLY = 0 and gnt = 1 on the same edge: pass, stay IDLE.
  - Otherwise: go to WAIT with k = 1.
- IDLE, req = 0: stay IDLE.
- WAIT: gnt is evaluated on each edge at the current k.
  - k < MIN_DLY: gnt is ignored; k increments.
  - MIN_DLY <= k <= MAX_DLY and gnt = 1: pass, go to IDLE.
  - k == MAX_DLY and gnt = 0: fail, go to IDLE.
  - Otherwise: k increments.
- UNBOUNDED = 1: fail is never raised. k saturates at 255 and the channel keeps waiting for gnt.
- Attempts do not overlap. req sampled while in WAIT, or on the verdict edge, is ignored and neither arms nor counts an attempt.
- pending = 1 exactly while the FSM is in WAIT.
- Counters:
  - On each edge, pass_cnt += popcount(pass_next) and fail_cnt += popcount(fail_next), where pass_next/fail_next are the verdicts being registered on that edge.
  - Sums are computed at CNT_W+6 bits and clamped to 2^CNT_W − 1.
  - Once saturated, a counter holds its value.
- clr = 1: on that edge all channels go to IDLE and both counters go to 0. No pass/fail is issued on that edge, even if a verdict was due. req sampled on the clr edge is ignored.
- rst: all FSMs go to IDLE, k = 0, and all outputs reset to 0 (pending, pass, fail, pass_cnt, fail_cnt). An attempt interrupted by reset produces no verdict.

## Timing
- Verdicts are registered. pass/fail go high in the cycle after the deciding posedge and last exactly one cycle.
- Constant delay D (MIN = MAX = D): with a trigger at edge t, gnt is sampled at edge t+D. The verdict pulse is visible during the cycle after edge t+D.
- pending rises in the cycle after the trigger edge. It falls in the same cycle that the verdict pulse is visible.
- Counters update on the same edge that registers pass/fail, so they are coherent with the pulses.
- pass and fail are never high together on the same channel.
- Channels are fully independent. Verdicts on several channels on the same edge are all counted on that edge.

## Test plan
- NCH=2, MIN=MAX=3. req[0]=1 at edge 1; gnt[0]=1 at edge 4 -> pass[0]=1 for one cycle after edge 4; pass_cnt=1; fail_cnt=0.
- Same config, gnt[0]=0 at edge 4 (gnt[0]=1 at edge 3 or edge 5 has no effect) -> fail[0] after edge 4; fail_cnt=1. req[0] held high through edges 2..4 arms no extra attempts. Re-arm at edge 5.
- MIN=2, MAX=4:
  - gnt at k=1 only -> fail after k=4.
  - gnt at k=3 -> pass after k=3.
  - Simultaneously, channel 1 sees gnt at k=2 on the same edge as channel 0's pass -> pass_cnt increments by 2 on that edge.
- UNBOUNDED=1, MIN=1. gnt withheld for 300 cycles -> pending stays 1, no fail. gnt at cycle 301 -> pass, pending=0.
- Reset and clr during an attempt:
  - Async rst asserted mid-cycle at k=2 of a D=3 attempt -> all outputs 0 immediately. No verdict follows. After release, a new trigger works normally.
  - clr on the verdict edge -> no pulse and counters read 0.
- CNT_W=2, 5 consecutive failing attempts -> fail_cnt sequence 1,2,3,3,3 and no wrap.
